// File: rtl/wb_pkg.sv
// Shared widths, the zero-register address and the queue entry layout
// for the register-file writeback queue.
package wb_pkg;

    localparam int unsigned REG_W  = 64;
    localparam int unsigned ADDR_W = 5;
    localparam logic [ADDR_W-1:0] XZR = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Bypass lookup: scans occupied entries oldest-to-youngest starting at the read
// pointer, so the last match found is the youngest pending write.
module wb_match
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
    input  logic [DEPTH-1:0][REG_W-1:0]  datas,
    input  logic [DEPTH-1:0]             valid,
    input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
    input  logic [ADDR_W-1:0]            ra,
    output logic                         hit,
    output logic [REG_W-1:0]             fwd
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    always_comb begin
        hit = 1'b0;
        fwd = '0;
        idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (valid[idx] && (addrs[idx] == ra) && (ra != XZR)) begin
                hit = 1'b1;
                fwd = datas[idx];
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Small FIFO between execute results and the register-file write port, with
// two bypass lookups over the pending (not yet written) entries.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [REG_W-1:0]         in_data,
    input  logic                     wb_stall,
    output logic                     we3,
    output logic [ADDR_W-1:0]        wa3,
    output logic [REG_W-1:0]         wd3,
    input  logic [ADDR_W-1:0]        ra1,
    input  logic [ADDR_W-1:0]        ra2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [REG_W-1:0]         fwd1,
    output logic [REG_W-1:0]         fwd2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t               mem_q [DEPTH];
    logic [DEPTH-1:0]        valid_q;
    logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]           count_q, count_d;
    logic                    push, pop, not_empty;
    wb_entry_t               head;

    logic [DEPTH-1:0][ADDR_W-1:0] m_addr;
    logic [DEPTH-1:0][REG_W-1:0]  m_data;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != CW'(DEPTH));
    // XZR writes are handshaken but never stored.
    assign push      = in_valid && in_ready && (in_addr != XZR);
    assign we3       = not_empty && !wb_stall;
    assign pop       = we3;
    assign head      = mem_q[rd_ptr_q];
    assign wa3       = not_empty ? head.addr : '0;
    assign wd3       = not_empty ? head.data : '0;
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            count_q <= count_d;
            if (pop) begin
                rd_ptr_q          <= rd_ptr_q + PW'(1);
                valid_q[rd_ptr_q] <= 1'b0;
            end
            // Push and pop never target the same slot: that needs empty or full.
            if (push) begin
                wr_ptr_q          <= wr_ptr_q + PW'(1);
                valid_q[wr_ptr_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{addr: in_addr, data: in_data};
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
        assign m_addr[g] = mem_q[g].addr;
        assign m_data[g] = mem_q[g].data;
    end

    wb_match #(.DEPTH(DEPTH)) u_match1 (
        .addrs  (m_addr),
        .datas  (m_data),
        .valid  (valid_q),
        .rd_ptr (rd_ptr_q),
        .ra     (ra1),
        .hit    (hit1),
        .fwd    (fwd1)
    );

    wb_match #(.DEPTH(DEPTH)) u_match2 (
        .addrs  (m_addr),
        .datas  (m_data),
        .valid  (valid_q),
        .rd_ptr (rd_ptr_q),
        .ra     (ra2),
        .hit    (hit2),
        .fwd    (fwd2)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: directed scenarios plus random traffic
// checked against a queue-based model of pending writes.
module tb_writeback_queue;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [63:0] in_data;
    logic        wb_stall;
    logic        we3;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic [4:0]  ra1, ra2;
    logic        hit1, hit2;
    logic [63:0] fwd1, fwd2;
    logic [2:0]  count;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .wb_stall (wb_stall),
        .we3      (we3),
        .wa3      (wa3),
        .wd3      (wd3),
        .ra1      (ra1),
        .ra2      (ra2),
        .hit1     (hit1),
        .hit2     (hit2),
        .fwd1     (fwd1),
        .fwd2     (fwd2),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t        exp_q[$];
    logic        acc_pend;
    ent_t        acc_ent;
    logic [63:0] rf [32];
    int          n_checks;
    int          n_fail;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Youngest pending write to ra, from the model queue.
    function automatic void lookup(input logic [4:0] ra, output logic h, output logic [63:0] f);
        h = 1'b0;
        f = '0;
        if (ra != 5'd31) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].a == ra) begin
                    h = 1'b1;
                    f = exp_q[i].d;
                    break;
                end
            end
        end
    endfunction

    // Monitor: compare outputs to the model, pop the model when a write is presented.
    always @(negedge clk) begin
        int          n;
        logic        h1, h2;
        logic [63:0] f1, f2;
        n = exp_q.size();
        chk("count", 64'(count), 64'(n));
        chk("in_ready", 64'(in_ready), 64'(n != DEPTH));
        chk("we3", 64'(we3), 64'((n != 0) && !wb_stall));
        if (n != 0) begin
            chk("wa3", 64'(wa3), 64'(exp_q[0].a));
            chk("wd3", wd3, exp_q[0].d);
        end else begin
            chk("wa3_empty", 64'(wa3), 64'(0));
            chk("wd3_empty", wd3, 64'(0));
        end
        lookup(ra1, h1, f1);
        lookup(ra2, h2, f2);
        chk("hit1", 64'(hit1), 64'(h1));
        chk("fwd1", fwd1, f1);
        chk("hit2", 64'(hit2), 64'(h2));
        chk("fwd2", fwd2, f2);
        acc_pend = reset_n && in_valid && (n != DEPTH) && (in_addr != 5'd31);
        acc_ent  = '{a: in_addr, d: in_data};
        if (we3) begin
            if (n == 0) chk("write_from_empty", 64'(we3), 64'(0));
            else void'(exp_q.pop_front());
        end
    end

    always @(posedge clk) begin
        if (reset_n && acc_pend) exp_q.push_back(acc_ent);
        acc_pend = 1'b0;
        if (we3) rf[wa3] <= wd3;
    end

    always @(negedge reset_n) begin
        exp_q.delete();
        acc_pend = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [63:0] d);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (count == 3'd0) break;
            tick();
        end
        chk("drain_empty", 64'(count), 64'(0));
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        acc_pend = 1'b0;
        reset_n  = 1'b0;
        wb_stall = 1'b0;
        ra1      = 5'd0;
        ra2      = 5'd0;
        drive(1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 32; i++) rf[i] = '0;

        @(negedge clk);
        chk("rst_we3", 64'(we3), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(1));
        tick();
        #1 reset_n = 1'b1;
        tick();

        // Single write
        drive(1'b1, 5'd5, 64'd15);
        tick();
        drive(1'b0, 5'd0, 64'd0);
        @(negedge clk);
        chk("single_we3", 64'(we3), 64'(1));
        chk("single_wa3", 64'(wa3), 64'(5));
        chk("single_wd3", wd3, 64'd15);
        chk("single_cnt1", 64'(count), 64'(1));
        tick();
        @(negedge clk);
        chk("single_cnt0", 64'(count), 64'(0));
        chk("single_rf5", rf[5], 64'd15);
        tick();

        // Fill while stalled, then release
        wb_stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 5'(i), 64'(10 * i));
            @(negedge clk);
            chk("fill_ready", 64'(in_ready), 64'(i <= 4));
            tick();
        end
        @(negedge clk);
        chk("fill_cnt", 64'(count), 64'(4));
        tick();
        wb_stall = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("fill_order_we", 64'(we3), 64'(1));
            chk("fill_order_wa", 64'(wa3), 64'(k));
            chk("fill_order_wd", wd3, 64'(10 * k));
            tick();
            if (k == 2) drive(1'b0, 5'd0, 64'd0);
        end
        drain();

        // XZR is dropped
        ra1 = 5'd31;
        drive(1'b1, 5'd31, 64'd4);
        @(negedge clk);
        chk("xzr_ready", 64'(in_ready), 64'(1));
        chk("xzr_hit_cur", 64'(hit1), 64'(0));
        tick();
        drive(1'b0, 5'd0, 64'd0);
        @(negedge clk);
        chk("xzr_cnt", 64'(count), 64'(0));
        chk("xzr_we3", 64'(we3), 64'(0));
        chk("xzr_hit", 64'(hit1), 64'(0));
        tick();

        // Bypass picks the youngest match
        wb_stall = 1'b1;
        drive(1'b1, 5'd7, 64'd100);
        tick();
        drive(1'b1, 5'd7, 64'd200);
        tick();
        drive(1'b0, 5'd0, 64'd0);
        ra1 = 5'd7;
        ra2 = 5'd8;
        @(negedge clk);
        chk("byp_hit1", 64'(hit1), 64'(1));
        chk("byp_fwd1", fwd1, 64'd200);
        chk("byp_hit2", 64'(hit2), 64'(0));
        chk("byp_fwd2", fwd2, 64'd0);
        tick();
        wb_stall = 1'b0;
        drain();

        // Back-to-back push/pop wraps the pointers
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'(i + 1), 64'(1000 + i));
            @(negedge clk);
            chk("wrap_cnt_le1", 64'(count <= 3'd1), 64'(1));
            tick();
        end
        drive(1'b0, 5'd0, 64'd0);
        drain();

        // Reset in the middle of a stalled queue
        wb_stall = 1'b1;
        ra1 = 5'd2;
        for (int i = 2; i <= 4; i++) begin
            drive(1'b1, 5'(i), 64'(i * 7));
            tick();
        end
        drive(1'b0, 5'd0, 64'd0);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_we3", 64'(we3), 64'(0));
        chk("midrst_cnt", 64'(count), 64'(0));
        chk("midrst_hit1", 64'(hit1), 64'(0));
        tick();
        reset_n  = 1'b1;
        wb_stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("postrst_we3", 64'(we3), 64'(0));
            tick();
        end

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            int r;
            r = int'($urandom_range(0, 9));
            drive($urandom_range(0, 99) < 60, (r == 9) ? 5'd31 : 5'(r),
                  {$urandom, $urandom});
            wb_stall = ($urandom_range(0, 99) < 30);
            r   = int'($urandom_range(0, 9));
            ra1 = (r == 9) ? 5'd31 : 5'(r);
            r   = int'($urandom_range(0, 9));
            ra2 = (r == 9) ? 5'd31 : 5'(r);
            tick();
        end
        drive(1'b0, 5'd0, 64'd0);
        wb_stall = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  producer offers a result.
REQ-005 SHALL have port in_ready  output  1  queue can accept this cycle.
REQ-006 SHALL have port in_addr  input  5  destination register.
REQ-007 SHALL have port in_data  input  64  result value.
REQ-008 SHALL have port wb_stall  input  1  regfile write port unavailable.
REQ-009 SHALL have port we3  output  1  regfile write enable.
REQ-010 SHALL have port wa3  output  5  regfile write address.
REQ-011 SHALL have port wd3  output  64  regfile write data.
REQ-012 SHALL have ports ra1, ra2  input  5 each  decode-stage read addresses for bypass lookup.
REQ-013 SHALL have ports hit1, hit2  output  1 each  pending write matches ra1/ra2.
REQ-014 SHALL have ports fwd1, fwd2  output  64 each  pending value for ra1/ra2.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-016 SHALL accept an entry on a rising edge where in_valid && in_ready.
REQ-017 SHALL drive in_ready = (count != DEPTH); no same-cycle pop-through when full.
REQ-018 SHALL accept but not enqueue entries with in_addr == 31 (XZR); count unchanged.
REQ-019 SHALL drive we3 = (count != 0) && !wb_stall, combinational from head and wb_stall.
REQ-020 SHALL drive wa3/wd3 from the head entry; wa3 = 0, wd3 = 0 when empty.
REQ-021 SHALL pop the head on a rising edge where we3 == 1.
REQ-022 Latency: entry accepted at edge t SHALL appear on we3/wa3/wd3 after edge t and be written into the regfile at edge t+1 when not stalled.
REQ-023 SHALL preserve FIFO order; entries with the same address SHALL be written oldest first.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and both pointers advanced.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 wb_stall SHALL hold head and count; pushes continue until full.
REQ-027 hitN SHALL be 1 when any occupied entry has addr == raN and raN != 31.
REQ-028 fwdN SHALL equal the data of the youngest matching occupied entry; 0 when hitN == 0.
REQ-029 Bypass SHALL include the head entry, including the cycle it is being written; SHALL exclude in_* of the current cycle.
REQ-030 count SHALL never exceed DEPTH nor underflow; overflow/underflow not reachable through the handshake.

Reset
REQ-031 reset_n low SHALL asynchronously clear pointers, count, and all entry-valid state.
REQ-032 During and after reset: we3 = 0, wa3 = 0, wd3 = 0, hit1 = hit2 = 0, fwd1 = fwd2 = 0, in_ready = 1.
REQ-033 Reset mid-operation SHALL discard all queued entries; none written afterwards.
REQ-034 Entry data storage need not be reset.

Structure
REQ-035 Package wb_pkg SHALL hold REG_W = 64, ADDR_W = 5, XZR = 5'd31, and typedef wb_entry_t {addr, data}.
REQ-036 The priority match (youngest hit over entries, given read pointer) SHALL be sub-module wb_match, instantiated once per read port.

Verification
REQ-037 Single write: push (5, 15), no stall -> we3 = 1, wa3 = 5, wd3 = 15 for one cycle; regfile X5 reads 15 next cycle; count 1 -> 0.
REQ-038 Fill: wb_stall = 1, push addr 1..5 data 10..50 -> first 4 accepted, in_ready = 0 on 5th, count = 4; release stall -> writes 1,2,3,4 in order on consecutive cycles, then 5.
REQ-039 XZR drop: push (31, 4) -> in_ready = 1, count stays 0, we3 stays 0, hit = 0 for ra1 = 31.
REQ-040 Bypass youngest: stall, push (7, 100) then (7, 200), ra1 = 7 -> hit1 = 1, fwd1 = 200; ra2 = 8 -> hit2 = 0, fwd2 = 0.
REQ-041 Wrap: 10 back-to-back pushes with simultaneous pops, DEPTH = 4 -> count never > 1, all 10 written in order.
REQ-042 Reset mid-op: 3 queued, stalled, pulse reset_n low -> we3 = 0, count = 0 immediately; no writes after release.
